// File: rtl/signature_frame_pkg.sv
// Shared types and constants for the signature frame packer.
// Frame layout: sync, sequence, payload bytes, XOR checksum.
package signature_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_PAYLOAD,
        ST_CSUM
    } frame_state_e;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         FRAME_OVERHEAD    = 3;

endpackage

// File: rtl/byte_sync_fifo.sv
// Byte FIFO with first-word fall-through read data and an occupancy count.
// A write into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_sync_fifo #(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_wr, do_rd;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_wr && !do_rd)      count_q <= count_q + 1'b1;
            else if (!do_wr && do_rd) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/signature_frame_packer.sv
// Buffers recovered bytes and emits sync/seq/payload/checksum frames to a UART.
// A frame starts only once its full payload is buffered, so it never stalls mid-frame.
module signature_frame_packer
    import signature_frame_pkg::*;
#(
    parameter int         PAYLOAD_LEN = 8,
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    input  logic       tx_busy,
    output logic       out_en,
    output logic [7:0] out_byte,
    output logic       overflow,
    output logic [7:0] frame_count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(PAYLOAD_LEN + 1);

    frame_state_e  state_q, state_d;
    phase_e        phase_q, phase_d;
    logic          guard_q, guard_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    seq_q, seq_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    out_byte_q, out_byte_d;
    logic          out_en_q, out_en_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;

    logic          rd_en;
    logic [7:0]    rd_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;

    byte_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_byte),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        guard_d     = guard_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        csum_d      = csum_q;
        out_byte_d  = out_byte_q;
        out_en_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        rd_en       = 1'b0;

        if (state_q == ST_IDLE) begin
            idx_d = '0;
            if (fifo_count >= CW'(PAYLOAD_LEN)) begin
                state_d = ST_SYNC;
                phase_d = PH_ISSUE;
            end
        end else if (phase_q == PH_ISSUE) begin
            if (!tx_busy) begin
                out_en_d = 1'b1;
                phase_d  = PH_WAIT;
                guard_d  = 1'b1;
                case (state_q)
                    ST_SYNC: out_byte_d = SYNC_BYTE;
                    ST_SEQ: begin
                        out_byte_d = seq_q;
                        csum_d     = seq_q;
                    end
                    ST_PAYLOAD: begin
                        rd_en      = !fifo_empty;
                        out_byte_d = rd_data;
                        csum_d     = csum_q ^ rd_data;
                        idx_d      = idx_q + 1'b1;
                    end
                    default: out_byte_d = csum_q;
                endcase
            end
        end else if (guard_q) begin
            // UART raises busy one cycle late; skip sampling it here.
            guard_d = 1'b0;
        end else if (!tx_busy) begin
            phase_d = PH_ISSUE;
            case (state_q)
                ST_SYNC:    state_d = ST_SEQ;
                ST_SEQ:     state_d = ST_PAYLOAD;
                ST_PAYLOAD: state_d = (idx_q == IW'(PAYLOAD_LEN)) ? ST_CSUM : ST_PAYLOAD;
                default: begin
                    state_d     = ST_IDLE;
                    seq_d       = seq_q + 8'd1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            endcase
        end

        overflow_d = overflow_q || (in_valid && fifo_full && !rd_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_ISSUE;
            guard_q     <= 1'b0;
            idx_q       <= '0;
            seq_q       <= '0;
            csum_q      <= '0;
            out_byte_q  <= '0;
            out_en_q    <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            guard_q     <= guard_d;
            idx_q       <= idx_d;
            seq_q       <= seq_d;
            csum_q      <= csum_d;
            out_byte_q  <= out_byte_d;
            out_en_q    <= out_en_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign out_en      = out_en_q;
    assign out_byte    = out_byte_q;
    assign overflow    = overflow_q;
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_signature_frame_packer.sv
// Scoreboard bench for signature_frame_packer: stimulus queues expected UART bytes,
// a monitor pops and compares on every out_en strobe.
module tb_signature_frame_packer;

    logic       clk = 1'b0;
    logic       rst, in_valid, tx_busy;
    logic [7:0] in_byte;
    logic       out_en, overflow;
    logic [7:0] out_byte, frame_count;

    logic force_busy = 1'b0;
    logic uart_busy  = 1'b0;
    logic uart_mode  = 1'b0;
    logic mon_on     = 1'b0;
    assign tx_busy = force_busy | uart_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    logic [7:0] sb [$];
    logic [7:0] seq_exp, fc_exp;

    always #5 clk = ~clk;

    signature_frame_packer #(.PAYLOAD_LEN(8), .FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .tx_busy     (tx_busy),
        .out_en      (out_en),
        .out_byte    (out_byte),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: byte order, busy gating and out_byte stability between strobes.
    initial begin
        logic [7:0] last_byte, exp;
        logic prev_busy, rst_prev;
        last_byte = 8'h00; prev_busy = 1'b0; rst_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (rst_prev) last_byte = 8'h00;
                if (out_en === 1'b1) begin
                    n_out++;
                    chk("busy_gate", {31'd0, prev_busy}, 32'd0);
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_byte: got %02h, no byte expected", out_byte);
                    end else begin
                        exp = sb.pop_front();
                        chk("out_byte", {24'd0, out_byte}, {24'd0, exp});
                    end
                    last_byte = out_byte;
                end else begin
                    chk("out_byte_stable", {24'd0, out_byte}, {24'd0, last_byte});
                end
            end
            prev_busy = tx_busy;
            rst_prev  = rst;
        end
    end

    // UART model: busy rises one cycle after out_en and holds for 20 cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_mode && out_en === 1'b1) begin
                @(posedge clk); #1 uart_busy = 1'b1;
                repeat (20) @(posedge clk);
                #1 uart_busy = 1'b0;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_run(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) send(base + 8'(i));
    endtask

    task automatic push_frame(input logic [7:0] s, input logic [7:0] base);
        logic [7:0] c, b;
        c = s;
        sb.push_back(8'hA5);
        sb.push_back(s);
        for (int i = 0; i < 8; i++) begin
            b = base + 8'(i);
            c = c ^ b;
            sb.push_back(b);
        end
        sb.push_back(c);
    endtask

    task automatic drain(input string nm, input int bound, input int tail);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(posedge clk); #1; n++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d bytes never sent, expected 0 within %0d cycles", nm, sb.size(), bound);
            sb.delete();
        end
        repeat (tail) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] t1 [11];
        int n0, lat, n;
        t1 = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_on = 1'b1;
        chk("rst_out_en", {31'd0, out_en}, 32'd0);
        chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_frame_count", {24'd0, frame_count}, 32'd0);

        // 1: basic frame, hand-computed bytes
        foreach (t1[i]) sb.push_back(t1[i]);
        send_run(8'h01, 8);
        drain("t1_drain", 200, 6);
        chk("t1_frame_count", {24'd0, frame_count}, 32'd1);
        seq_exp = 8'h01; fc_exp = 8'd1;

        // 2: UART busy after every strobe; next frame uses seq 01
        uart_mode = 1'b1;
        push_frame(seq_exp, 8'h01);
        send_run(8'h01, 8);
        drain("t2_drain", 2000, 30);
        uart_mode = 1'b0;
        seq_exp++; fc_exp++;
        chk("t2_frame_count", {24'd0, frame_count}, {24'd0, fc_exp});
        chk("t2_overflow", {31'd0, overflow}, 32'd0);

        // 3: 20 writes while busy: 16 kept, 4 dropped
        force_busy = 1'b1;
        send_run(8'h01, 20);
        repeat (3) @(posedge clk); #1;
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        chk("t3_no_out_while_busy", {24'd0, 8'(sb.size())}, 32'd0);
        push_frame(seq_exp, 8'h01);
        push_frame(seq_exp + 8'd1, 8'h09);
        force_busy = 1'b0;
        drain("t3_drain", 400, 6);
        seq_exp += 8'd2; fc_exp += 8'd2;
        chk("t3_frame_count", {24'd0, frame_count}, {24'd0, fc_exp});
        chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

        // 4: 7 bytes never start a frame; the 8th starts SYNC within 2 cycles
        n0 = n_out;
        send_run(8'h60, 7);
        repeat (1000) @(posedge clk); #1;
        chk("t4_no_frame_7_bytes", n_out, n0);
        push_frame(seq_exp, 8'h60);
        send(8'h67);
        lat = 0;
        while (out_en !== 1'b1 && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        n_cmp++;
        if (lat > 2) begin
            n_bad++;
            $display("FAIL t4_sync_latency: got %0d cycles, expected <= 2", lat);
        end
        drain("t4_drain", 200, 6);
        seq_exp++; fc_exp++;
        chk("t4_frame_count", {24'd0, frame_count}, {24'd0, fc_exp});
        chk("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

        // 5: reset during the 4th payload byte
        sb.push_back(8'hA5); sb.push_back(seq_exp);
        sb.push_back(8'h31); sb.push_back(8'h32); sb.push_back(8'h33); sb.push_back(8'h34);
        n0 = n_out;
        send_run(8'h31, 8);
        n = 0;
        while (n_out < n0 + 6 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("t5_reached_payload4", n_out, n0 + 6);
        @(posedge clk); #1 rst = 1'b1;
        send(8'hEE);
        rst = 1'b0;
        chk("t5_out_en", {31'd0, out_en}, 32'd0);
        chk("t5_out_byte", {24'd0, out_byte}, 32'd0);
        chk("t5_overflow", {31'd0, overflow}, 32'd0);
        chk("t5_frame_count", {24'd0, frame_count}, 32'd0);
        chk("t5_queue_empty", sb.size(), 0);
        n0 = n_out;
        repeat (50) @(posedge clk); #1;
        chk("t5_no_partial", n_out, n0);
        seq_exp = 8'h00; fc_exp = 8'd0;
        push_frame(seq_exp, 8'h51);
        send_run(8'h51, 8);
        drain("t5_drain", 200, 6);
        seq_exp++; fc_exp++;
        chk("t5_frame_count_after", {24'd0, frame_count}, {24'd0, fc_exp});

        // 6: 257 frames, seq and frame_count wrap
        for (int f = 0; f < 257; f++) begin
            push_frame(seq_exp, 8'(f * 37));
            send_run(8'(f * 37), 8);
            drain("t6_drain", 200, 4);
            seq_exp++; fc_exp++;
            chk("t6_frame_count", {24'd0, frame_count}, {24'd0, fc_exp});
        end
        chk("t6_overflow", {31'd0, overflow}, 32'd0);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
